// File: rtl/accel_desc_sched.sv
// Descriptor scheduler: in-order FIFO of DMA descriptors feeding one registered
// output slot that issues only to accelerators with no descriptor in flight.
module accel_desc_sched #(
    parameter int ACCEL_COUNT = 13,
    parameter int DEST_WIDTH  = $clog2(ACCEL_COUNT),
    parameter int ADDR_WIDTH  = 16,
    parameter int LEN_WIDTH   = 14,
    parameter int DEPTH       = 8,
    parameter int CNT_WIDTH   = $clog2(DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DEST_WIDTH-1:0]  s_desc_accel_id,
    input  logic [ADDR_WIDTH-1:0]  s_desc_addr,
    input  logic [LEN_WIDTH-1:0]   s_desc_len,
    input  logic                   s_desc_valid,
    output logic                   s_desc_ready,
    output logic [DEST_WIDTH-1:0]  m_desc_accel_id,
    output logic [ADDR_WIDTH-1:0]  m_desc_addr,
    output logic [LEN_WIDTH-1:0]   m_desc_len,
    output logic                   m_desc_valid,
    input  logic                   m_desc_ready,
    input  logic [ACCEL_COUNT-1:0] accel_done,
    input  logic [ACCEL_COUNT-1:0] accel_stop,
    output logic [ACCEL_COUNT-1:0] inflight,
    output logic [CNT_WIDTH-1:0]   queue_count,
    output logic                   error,
    input  logic                   error_ack
);
    localparam int PTR_WIDTH = $clog2(DEPTH);

    typedef struct packed {
        logic [DEST_WIDTH-1:0] accel_id;
        logic [ADDR_WIDTH-1:0] addr;
        logic [LEN_WIDTH-1:0]  len;
    } desc_t;

    desc_t                  mem_q [DEPTH];
    logic [CNT_WIDTH-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    desc_t                  slot_q, slot_d;
    logic                   slot_valid_q, slot_valid_d;
    logic [ACCEL_COUNT-1:0] inflight_q, inflight_d;
    logic                   error_q, error_d;

    logic [CNT_WIDTH-1:0]   count;
    logic                   accept, bad, push, pop;
    logic                   handshake, slot_free, head_blocked;
    logic [ACCEL_COUNT-1:0] slot_onehot, reserved;
    desc_t                  head;

    assign count        = wr_ptr_q - rd_ptr_q;
    assign s_desc_ready = !rst && (count < CNT_WIDTH'(DEPTH));
    assign accept       = s_desc_valid && s_desc_ready;
    assign bad          = (s_desc_len == '0) || (int'(s_desc_accel_id) >= ACCEL_COUNT);
    assign push         = accept && !bad;
    assign head         = mem_q[rd_ptr_q[PTR_WIDTH-1:0]];
    assign handshake    = slot_valid_q && m_desc_ready;
    assign slot_free    = !slot_valid_q || m_desc_ready;

    // The slot's own target counts as busy, so the same accelerator can never be
    // issued twice back-to-back before its in-flight bit is visible.
    always_comb begin
        slot_onehot  = '0;
        head_blocked = 1'b0;
        for (int unsigned i = 0; i < ACCEL_COUNT; i++) begin
            if (slot_valid_q && (slot_q.accel_id == DEST_WIDTH'(i))) slot_onehot[i] = 1'b1;
        end
        reserved = inflight_q | slot_onehot;
        for (int unsigned i = 0; i < ACCEL_COUNT; i++) begin
            if ((head.accel_id == DEST_WIDTH'(i)) && reserved[i]) head_blocked = 1'b1;
        end
    end

    assign pop = (count != '0) && slot_free && !head_blocked;

    always_comb begin
        wr_ptr_d     = wr_ptr_q + CNT_WIDTH'(push);
        rd_ptr_d     = rd_ptr_q + CNT_WIDTH'(pop);
        slot_valid_d = pop || (slot_valid_q && !m_desc_ready);
        slot_d       = pop ? head : slot_q;
        inflight_d   = (inflight_q & ~(accel_done | accel_stop)) | (handshake ? slot_onehot : '0);
        error_d      = (accept && bad) || (error_q && !error_ack);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            slot_q       <= '0;
            slot_valid_q <= 1'b0;
            inflight_q   <= '0;
            error_q      <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            slot_q       <= slot_d;
            slot_valid_q <= slot_valid_d;
            inflight_q   <= inflight_d;
            error_q      <= error_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[PTR_WIDTH-1:0]] <= {s_desc_accel_id, s_desc_addr, s_desc_len};
    end

    assign m_desc_accel_id = slot_q.accel_id;
    assign m_desc_addr     = slot_q.addr;
    assign m_desc_len      = slot_q.len;
    assign m_desc_valid    = slot_valid_q;
    assign inflight        = inflight_q;
    assign queue_count     = count;
    assign error           = error_q;

endmodule

// File: tb/tb_accel_desc_sched.sv
// Bench for accel_desc_sched: directed scenarios plus random traffic, checked
// every cycle against a queue-based model of the scheduler.
module tb_accel_desc_sched;
    localparam int AC = 13;
    localparam int DW = 4;
    localparam int AW = 16;
    localparam int LW = 14;
    localparam int DEPTH = 8;
    localparam int CW = 4;

    logic          clk, rst;
    logic [DW-1:0] s_desc_accel_id;
    logic [AW-1:0] s_desc_addr;
    logic [LW-1:0] s_desc_len;
    logic          s_desc_valid, s_desc_ready;
    logic [DW-1:0] m_desc_accel_id;
    logic [AW-1:0] m_desc_addr;
    logic [LW-1:0] m_desc_len;
    logic          m_desc_valid, m_desc_ready;
    logic [AC-1:0] accel_done, accel_stop, inflight;
    logic [CW-1:0] queue_count;
    logic          error, error_ack;

    accel_desc_sched #(
        .ACCEL_COUNT(AC), .DEST_WIDTH(DW), .ADDR_WIDTH(AW),
        .LEN_WIDTH(LW), .DEPTH(DEPTH), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .s_desc_accel_id(s_desc_accel_id), .s_desc_addr(s_desc_addr),
        .s_desc_len(s_desc_len), .s_desc_valid(s_desc_valid), .s_desc_ready(s_desc_ready),
        .m_desc_accel_id(m_desc_accel_id), .m_desc_addr(m_desc_addr),
        .m_desc_len(m_desc_len), .m_desc_valid(m_desc_valid), .m_desc_ready(m_desc_ready),
        .accel_done(accel_done), .accel_stop(accel_stop), .inflight(inflight),
        .queue_count(queue_count), .error(error), .error_ack(error_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of pending descriptors, one output slot, a busy set.
    typedef struct {
        int id;
        int addr;
        int len;
    } mdesc_t;

    mdesc_t  mq[$];
    mdesc_t  ms;
    bit      mv;
    bit [AC-1:0] minf;
    bit      merr;

    task automatic model_step();
        bit hs, pop, acc, badd;
        mdesc_t h, n;
        if (rst) begin
            mq.delete();
            ms = '{0, 0, 0};
            mv = 0;
            minf = '0;
            merr = 0;
            return;
        end
        acc  = s_desc_valid && (mq.size() < DEPTH);
        badd = (s_desc_len == 0) || (int'(s_desc_accel_id) >= AC);
        hs   = mv && m_desc_ready;
        pop  = 0;
        if (mq.size() > 0 && (!mv || m_desc_ready)) begin
            h = mq[0];
            pop = !minf[h.id] && !(mv && ms.id == h.id);
        end
        minf = (minf & ~(accel_done | accel_stop)) | (hs ? (AC'(1) << ms.id) : AC'(0));
        if (pop) begin
            ms = mq.pop_front();
            mv = 1;
        end else if (hs) begin
            mv = 0;
        end
        if (acc && !badd) begin
            n.id = int'(s_desc_accel_id);
            n.addr = int'(s_desc_addr);
            n.len = int'(s_desc_len);
            mq.push_back(n);
        end
        if (acc && badd) merr = 1;
        else if (error_ack) merr = 0;
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("s_desc_ready", 32'(s_desc_ready), 32'(!rst && mq.size() < DEPTH));
            chk("m_desc_valid", 32'(m_desc_valid), 32'(mv));
            if (mv) begin
                chk("m_desc_accel_id", 32'(m_desc_accel_id), ms.id);
                chk("m_desc_addr", 32'(m_desc_addr), ms.addr);
                chk("m_desc_len", 32'(m_desc_len), ms.len);
            end
            chk("inflight", 32'(inflight), 32'(minf));
            chk("queue_count", 32'(queue_count), mq.size());
            chk("error", 32'(error), 32'(merr));
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Presents a descriptor and returns right after the edge that accepts it;
    // valid stays high so the caller can chain or drop it.
    task automatic send(input int id, input int addr, input int len);
        int k;
        s_desc_accel_id = DW'(id);
        s_desc_addr = AW'(addr);
        s_desc_len = LW'(len);
        s_desc_valid = 1'b1;
        k = 0;
        while (!s_desc_ready && k < 100) begin
            tick();
            k++;
        end
        if (k == 100) chk("send_timeout", 32'(s_desc_ready), 32'd1);
        tick();
    endtask

    task automatic pulse_done(input logic [AC-1:0] m);
        accel_done = m;
        tick();
        accel_done = '0;
    endtask

    initial begin
        rst = 1'b1;
        s_desc_accel_id = '0; s_desc_addr = '0; s_desc_len = '0; s_desc_valid = 1'b0;
        m_desc_ready = 1'b0; accel_done = '0; accel_stop = '0; error_ack = 1'b0;
        tick(); tick();
        chk("rst_s_ready", 32'(s_desc_ready), 32'd0);
        chk("rst_m_valid", 32'(m_desc_valid), 32'd0);
        chk("rst_m_data", {m_desc_accel_id, m_desc_addr, m_desc_len}, 32'd0);
        chk("rst_inflight", 32'(inflight), 32'd0);
        chk("rst_count", 32'(queue_count), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_ready", 32'(s_desc_ready), 32'd1);

        // Three accelerators, back-to-back issue starting two cycles after acceptance.
        m_desc_ready = 1'b1;
        send(0, 'h100, 64);
        chk("t1_not_yet", 32'(m_desc_valid), 32'd0);
        send(1, 'h200, 64);
        chk("t1_first_valid", 32'(m_desc_valid), 32'd1);
        chk("t1_first_id", 32'(m_desc_accel_id), 32'd0);
        chk("t1_first_addr", 32'(m_desc_addr), 32'h100);
        send(2, 'h300, 64);
        s_desc_valid = 1'b0;
        chk("t1_second_id", 32'(m_desc_accel_id), 32'd1);
        tick();
        chk("t1_third_id", 32'(m_desc_accel_id), 32'd2);
        chk("t1_third_addr", 32'(m_desc_addr), 32'h300);
        tick();
        chk("t1_idle", 32'(m_desc_valid), 32'd0);
        chk("t1_inflight", 32'(inflight), 32'h007);
        pulse_done(13'h007);
        tick();

        // Same accelerator twice: second waits for done.
        send(5, 'h500, 32);
        send(5, 'h540, 48);
        s_desc_valid = 1'b0;
        repeat (4) tick();
        chk("t2_withheld", 32'(m_desc_valid), 32'd0);
        chk("t2_count", 32'(queue_count), 32'd1);
        chk("t2_inflight", 32'(inflight), 32'h020);
        pulse_done(13'h020);
        tick();
        chk("t2_issued", 32'(m_desc_valid), 32'd1);
        chk("t2_len", 32'(m_desc_len), 32'd48);
        tick();
        pulse_done(13'h020);
        tick();

        // Head-of-line blocking: accel 4 waits behind busy accel 3.
        send(3, 'h30, 16);
        s_desc_valid = 1'b0;
        repeat (4) tick();
        send(3, 'h31, 16);
        send(4, 'h40, 16);
        s_desc_valid = 1'b0;
        repeat (4) tick();
        chk("t3_blocked", 32'(m_desc_valid), 32'd0);
        chk("t3_count", 32'(queue_count), 32'd2);
        pulse_done(13'h008);
        tick();
        chk("t3_first_id", 32'(m_desc_accel_id), 32'd3);
        chk("t3_first_addr", 32'(m_desc_addr), 32'h31);
        tick();
        chk("t3_second_id", 32'(m_desc_accel_id), 32'd4);
        tick();

        // Fill the FIFO behind busy accel 4 with the DMA stalled.
        m_desc_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) send(4, 'h400 + i, 8 + i);
        s_desc_accel_id = 4'd4; s_desc_addr = 16'h4ff; s_desc_len = 14'd99;
        tick(); tick();
        chk("t4_full_count", 32'(queue_count), 32'd8);
        chk("t4_full_ready", 32'(s_desc_ready), 32'd0);
        pulse_done(13'h010);
        tick();
        chk("t4_reopen_count", 32'(queue_count), 32'd7);
        chk("t4_reopen_ready", 32'(s_desc_ready), 32'd1);
        tick();
        s_desc_valid = 1'b0;
        chk("t4_refill", 32'(queue_count), 32'd8);
        m_desc_ready = 1'b1;
        repeat (20) begin
            tick();
            pulse_done(13'h010);
            tick();
        end

        // Malformed descriptors and error acknowledge priority.
        send(2, 'h10, 0);
        send(13, 'h20, 16);
        s_desc_valid = 1'b0;
        chk("t5_error", 32'(error), 32'd1);
        chk("t5_nothing_queued", 32'(queue_count), 32'd0);
        tick();
        chk("t5_nothing_issued", 32'(m_desc_valid), 32'd0);
        error_ack = 1'b1;
        send(14, 'h30, 16);
        s_desc_valid = 1'b0;
        error_ack = 1'b0;
        chk("t5_set_wins", 32'(error), 32'd1);
        error_ack = 1'b1;
        tick();
        error_ack = 1'b0;
        chk("t5_ack_clears", 32'(error), 32'd0);

        // Reset mid-operation with a loaded slot and four queued.
        m_desc_ready = 1'b0;
        for (int i = 6; i <= 10; i++) send(i, 'h600 + i, 16);
        s_desc_valid = 1'b0;
        tick();
        chk("t6_slot_valid", 32'(m_desc_valid), 32'd1);
        chk("t6_queued", 32'(queue_count), 32'd4);
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", 32'(m_desc_valid), 32'd0);
        chk("t6_rst_count", 32'(queue_count), 32'd0);
        chk("t6_rst_inflight", 32'(inflight), 32'd0);
        tick(); tick();
        rst = 1'b0;
        m_desc_ready = 1'b1;
        repeat (5) tick();
        chk("t6_no_issue", 32'(m_desc_valid), 32'd0);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            s_desc_valid = ($urandom % 3) == 0;
            s_desc_accel_id = DW'(($urandom % 25 == 0) ? 13 + $urandom % 3 : $urandom % AC);
            s_desc_addr = AW'($urandom);
            s_desc_len = LW'(($urandom % 30 == 0) ? 0 : $urandom_range(1, 16383));
            m_desc_ready = ($urandom % 4) != 0;
            accel_done = '0;
            accel_stop = '0;
            for (int b = 0; b < AC; b++) begin
                accel_done[b] = ($urandom % 8) == 0;
                accel_stop[b] = ($urandom % 20) == 0;
            end
            error_ack = ($urandom % 10) == 0;
            rst = ($urandom % 600) == 0;
            tick();
        end
        rst = 1'b0;
        s_desc_valid = 1'b0;
        accel_done = '0;
        accel_stop = '0;
        error_ack = 1'b0;
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
